// File: rtl/sun_tracker.sv
// Two-axis solar tracker: turns east/west and north/south lux imbalance into timed
// azimuth/elevation motor steps with deadband, confirmation, settle time and runaway fault.
module sun_tracker #(
    parameter int DEADBAND      = 8,
    parameter int CONFIRM       = 3,
    parameter int STEP_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 5000,
    parameter int MAX_STEPS     = 64,
    parameter int NIGHT_LUX     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] n_lux,
    input  logic [7:0] e_lux,
    input  logic [7:0] s_lux,
    input  logic [7:0] w_lux,
    input  logic       sample_valid,
    output logic       az_east,
    output logic       az_west,
    output logic       el_north,
    output logic       el_south,
    output logic       busy,
    output logic       night,
    output logic       fault
);

    localparam int CYC_MAX = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CYC_MAX) + 1;
    localparam int CONF_W  = $clog2(CONFIRM + 1);
    localparam int STEP_W  = $clog2(MAX_STEPS + 1);

    localparam logic [8:0]        DB_LIM      = 9'(DEADBAND);
    localparam logic [7:0]        NIGHT_LIM   = 8'(NIGHT_LUX);
    localparam logic [CONF_W-1:0] CONF_MAX    = CONF_W'(CONFIRM);
    localparam logic [STEP_W-1:0] STEP_MAX    = STEP_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0]  STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, EVAL, MOVE_AZ, MOVE_EL, SETTLE, FAULT
    } state_t;

    state_t            state;
    logic [7:0]        n_r, e_r, s_r, w_r;
    logic [CONF_W-1:0] az_cnt, el_cnt;
    logic              az_dir, el_dir;
    logic [STEP_W-1:0] step_count;
    logic [CNT_W-1:0]  cyc;

    logic signed [8:0] d_ew, d_ns;
    logic              az_imb, el_imb, is_night;
    logic [CONF_W-1:0] az_nx, el_nx;
    logic [STEP_W-1:0] step_inc;

    function automatic logic [8:0] mag9(input logic signed [8:0] d);
        return d[8] ? unsigned'(-d) : unsigned'(d);
    endfunction

    // Confirmation counter: restart on a direction change, saturate at CONFIRM.
    function automatic logic [CONF_W-1:0] next_conf(input logic imb, input logic dir_new,
                                                    input logic dir_old,
                                                    input logic [CONF_W-1:0] c);
        if (!imb)
            return '0;
        else if (dir_new != dir_old)
            return CONF_W'(1);
        else if (c == CONF_MAX)
            return c;
        else
            return c + 1'b1;
    endfunction

    always_comb begin
        d_ew     = signed'({1'b0, e_r}) - signed'({1'b0, w_r});
        d_ns     = signed'({1'b0, n_r}) - signed'({1'b0, s_r});
        az_imb   = mag9(d_ew) > DB_LIM;
        el_imb   = mag9(d_ns) > DB_LIM;
        az_nx    = next_conf(az_imb, d_ew[8], az_dir, az_cnt);
        el_nx    = next_conf(el_imb, d_ns[8], el_dir, el_cnt);
        is_night = (n_r < NIGHT_LIM) && (e_r < NIGHT_LIM) &&
                   (s_r < NIGHT_LIM) && (w_r < NIGHT_LIM);
        step_inc = step_count + 1'b1;
    end

    // Sample capture: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && sample_valid) begin
            n_r <= n_lux;
            e_r <= e_lux;
            s_r <= s_lux;
            w_r <= w_lux;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            az_cnt     <= '0;
            el_cnt     <= '0;
            az_dir     <= 1'b0;
            el_dir     <= 1'b0;
            step_count <= '0;
            cyc        <= '0;
            az_east    <= 1'b0;
            az_west    <= 1'b0;
            el_north   <= 1'b0;
            el_south   <= 1'b0;
            busy       <= 1'b0;
            night      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        state <= EVAL;
                        busy  <= 1'b1;
                    end
                end
                EVAL: begin
                    if (is_night) begin
                        night      <= 1'b1;
                        az_cnt     <= '0;
                        el_cnt     <= '0;
                        step_count <= '0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end else begin
                        night <= 1'b0;
                        cyc   <= '0;
                        if (az_imb) az_dir <= d_ew[8];
                        if (el_imb) el_dir <= d_ns[8];
                        if (!az_imb && !el_imb) step_count <= '0;
                        // Azimuth wins a tie; the elevation count is carried forward.
                        if (az_nx == CONF_MAX) begin
                            az_cnt     <= '0;
                            el_cnt     <= el_nx;
                            step_count <= step_inc;
                            if (step_inc == STEP_MAX) begin
                                state <= FAULT;
                                fault <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state   <= MOVE_AZ;
                                az_east <= ~d_ew[8];
                                az_west <= d_ew[8];
                            end
                        end else if (el_nx == CONF_MAX) begin
                            az_cnt     <= az_nx;
                            el_cnt     <= '0;
                            step_count <= step_inc;
                            if (step_inc == STEP_MAX) begin
                                state <= FAULT;
                                fault <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state    <= MOVE_EL;
                                el_north <= ~d_ns[8];
                                el_south <= d_ns[8];
                            end
                        end else begin
                            az_cnt <= az_nx;
                            el_cnt <= el_nx;
                            state  <= IDLE;
                            busy   <= 1'b0;
                        end
                    end
                end
                MOVE_AZ, MOVE_EL: begin
                    if (cyc == STEP_LAST) begin
                        az_east  <= 1'b0;
                        az_west  <= 1'b0;
                        el_north <= 1'b0;
                        el_south <= 1'b0;
                        cyc      <= '0;
                        state    <= SETTLE;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                SETTLE: begin
                    if (cyc == SETTLE_LAST) begin
                        cyc   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sun_tracker.sv
// Directed bench for sun_tracker: full-timing instance plus a short-timing instance for runaway.
module tb_sun_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] n_lux, e_lux, s_lux, w_lux;
    logic       sample_valid;

    logic az_east, az_west, el_north, el_south, busy, night, fault;
    logic f_az_east, f_az_west, f_el_north, f_el_south, f_busy, f_night, f_fault;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sun_tracker dut (
        .clk(clk), .rst(rst),
        .n_lux(n_lux), .e_lux(e_lux), .s_lux(s_lux), .w_lux(w_lux),
        .sample_valid(sample_valid),
        .az_east(az_east), .az_west(az_west), .el_north(el_north), .el_south(el_south),
        .busy(busy), .night(night), .fault(fault)
    );

    sun_tracker #(.STEP_CYCLES(4), .SETTLE_CYCLES(6)) dut_fast (
        .clk(clk), .rst(rst),
        .n_lux(n_lux), .e_lux(e_lux), .s_lux(s_lux), .w_lux(w_lux),
        .sample_valid(sample_valid),
        .az_east(f_az_east), .az_west(f_az_west), .el_north(f_el_north), .el_south(f_el_south),
        .busy(f_busy), .night(f_night), .fault(f_fault)
    );

    // Motor-high cycle counts, sampled on the falling edge.
    int   ae_cnt = 0, aw_cnt = 0, en_cnt = 0, es_cnt = 0, overlap_cnt = 0, f_steps = 0;
    logic f_prev = 1'b0;

    always @(negedge clk) begin
        if (az_east)  ae_cnt++;
        if (az_west)  aw_cnt++;
        if (el_north) en_cnt++;
        if (el_south) es_cnt++;
        if ($countones({az_east, az_west, el_north, el_south}) > 1) overlap_cnt++;
        if (f_az_east && !f_prev) f_steps++;
        f_prev = f_az_east;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] n, input logic [7:0] e,
                        input logic [7:0] s, input logic [7:0] w);
        n_lux = n; e_lux = e; s_lux = s; w_lux = w;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic step(input logic [7:0] n, input logic [7:0] e,
                        input logic [7:0] s, input logic [7:0] w);
        int j;
        send(n, e, s, w);
        tick();
        j = 0;
        while (busy && j < 7000) begin
            tick();
            j++;
        end
        tick();
    endtask

    task automatic fstep(input logic [7:0] n, input logic [7:0] e,
                         input logic [7:0] s, input logic [7:0] w);
        int j;
        send(n, e, s, w);
        tick();
        j = 0;
        while (f_busy && j < 100) begin
            tick();
            j++;
        end
        tick();
    endtask

    function automatic int motor_total();
        return ae_cnt + aw_cnt + en_cnt + es_cnt;
    endfunction

    int m0, a0, w0, n0, s0, f0, samples;

    initial begin
        rst = 1'b1; sample_valid = 1'b0;
        n_lux = 8'd0; e_lux = 8'd0; s_lux = 8'd0; w_lux = 8'd0;
        tick(); tick();
        rst = 1'b0;
        check("reset_outputs", {az_east, az_west, el_north, el_south, busy, night, fault}, 0);
        check("reset_fast", {f_az_east, f_az_west, f_el_north, f_el_south, f_busy, f_night, f_fault}, 0);

        // Balanced light: never moves
        m0 = motor_total();
        repeat (3) step(8'd100, 8'd100, 8'd100, 8'd100);
        check("balanced_no_motion", motor_total() - m0, 0);

        // Three confirmations, exact step and settle timing
        a0 = ae_cnt;
        step(8'd100, 8'd120, 8'd100, 8'd100);
        step(8'd100, 8'd120, 8'd100, 8'd100);
        send(8'd100, 8'd120, 8'd100, 8'd100);
        check("eval_busy", {busy, az_east}, 2'b10);
        tick();
        check("step_start", {az_east, az_west, el_north, el_south}, 4'b1000);
        repeat (999) tick();
        check("step_last", az_east, 1);
        tick();
        check("step_end", {az_east, busy}, 2'b01);
        repeat (4999) tick();
        check("settle_last", busy, 1);
        tick();
        check("settle_done", busy, 0);
        check("step_len", ae_cnt - a0, 1000);

        // Deadband edge: 8 is not enough, 9 is
        m0 = motor_total();
        repeat (5) step(8'd100, 8'd108, 8'd100, 8'd100);
        check("deadband_8", motor_total() - m0, 0);
        a0 = ae_cnt; w0 = aw_cnt;
        repeat (3) step(8'd100, 8'd109, 8'd100, 8'd100);
        check("deadband_9_east", ae_cnt - a0, 1000);
        check("deadband_9_west", aw_cnt - w0, 0);

        // Direction flip restarts confirmation
        m0 = motor_total(); a0 = ae_cnt; w0 = aw_cnt;
        repeat (2) step(8'd100, 8'd120, 8'd100, 8'd100);
        repeat (2) step(8'd100, 8'd80, 8'd100, 8'd100);
        check("flip_no_early", motor_total() - m0, 0);
        step(8'd100, 8'd80, 8'd100, 8'd100);
        check("flip_west", aw_cnt - w0, 1000);
        check("flip_no_east", ae_cnt - a0, 0);

        // Both axes confirmed together: azimuth first
        a0 = ae_cnt; n0 = en_cnt;
        repeat (3) step(8'd150, 8'd150, 8'd100, 8'd100);
        check("priority_az", ae_cnt - a0, 1000);
        check("priority_el_wait", en_cnt - n0, 0);
        a0 = ae_cnt; n0 = en_cnt; s0 = es_cnt;
        repeat (3) step(8'd150, 8'd150, 8'd100, 8'd100);
        check("el_north_step", en_cnt - n0, 1000);
        check("el_no_south", es_cnt - s0, 0);
        check("az_resume", ae_cnt - a0, 1000);

        // Night
        m0 = motor_total();
        step(8'd10, 8'd10, 8'd10, 8'd10);
        check("night_flag", {night, busy}, 2'b10);
        check("night_no_motion", motor_total() - m0, 0);
        step(8'd100, 8'd100, 8'd100, 8'd100);
        check("day_clears_night", night, 0);
        check("one_motor_max", overlap_cnt, 0);

        // Runaway on the short-timing instance
        rst = 1'b1; tick(); rst = 1'b0;
        f0 = f_steps;
        samples = 0;
        while (!f_fault && samples < 300) begin
            fstep(8'd100, 8'd200, 8'd100, 8'd0);
            samples++;
        end
        check("runaway_samples", samples, 192);
        check("runaway_steps", f_steps - f0, 63);
        check("fault_state", {f_fault, f_busy, f_az_east, f_az_west, f_el_north, f_el_south}, 6'b100000);
        f0 = f_steps;
        repeat (3) fstep(8'd100, 8'd200, 8'd100, 8'd0);
        check("fault_ignores_samples", f_steps - f0, 0);
        check("fault_sticky", {f_fault, f_busy}, 2'b10);

        // Reset in the middle of a motor step
        rst = 1'b1; tick(); rst = 1'b0; tick();
        step(8'd100, 8'd200, 8'd100, 8'd0);
        step(8'd100, 8'd200, 8'd100, 8'd0);
        send(8'd100, 8'd200, 8'd100, 8'd0);
        tick();
        check("pre_rst_move", az_east, 1);
        rst = 1'b1;
        tick();
        check("rst_mid_move", {az_east, az_west, el_north, el_south, busy, fault}, 0);
        check("rst_clears_fault", f_fault, 0);
        rst = 1'b0;
        send(8'd100, 8'd100, 8'd100, 8'd100);
        check("idle_after_rst", busy, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
